// File: rtl/tech_ram_1r1w_bm_if.sv
// Write and read port bundle for tech_ram_1r1w_bm. The bench or the client logic uses the
// master modport; the RAM uses the slave modport.
interface tech_ram_1r1w_bm_if #(
    parameter int unsigned BIT_WIDTH  = 64,
    parameter int unsigned WORD_DEPTH = 256
);
    localparam int unsigned ADDR_WIDTH = $clog2(WORD_DEPTH);
    localparam int unsigned BM_WIDTH   = BIT_WIDTH / 8;

    logic                  init_busy_o;
    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [BM_WIDTH-1:0]   wr_bm_i;
    logic [BIT_WIDTH-1:0]  wr_dat_i;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [BIT_WIDTH-1:0]  rd_dat_o;
    logic                  rd_valid_o;

    modport master (
        input  init_busy_o, rd_dat_o, rd_valid_o,
        output wr_en_i, wr_addr_i, wr_bm_i, wr_dat_i, rd_en_i, rd_addr_i
    );

    modport slave (
        output init_busy_o, rd_dat_o, rd_valid_o,
        input  wr_en_i, wr_addr_i, wr_bm_i, wr_dat_i, rd_en_i, rd_addr_i
    );
endinterface

// File: rtl/tech_ram_1r1w_bm.sv
// 1R1W RAM with byte-mask writes, self-initialising to INIT_VAL after reset, 1 or 2 cycle reads.
// Define TECH_RAM_BYPASS_EN to forward a same-cycle same-address write into the read data.
module tech_ram_1r1w_bm #(
    parameter int unsigned          BIT_WIDTH    = 64,
    parameter int unsigned          WORD_DEPTH   = 256,
    parameter int unsigned          READ_LATENCY = 1,
    parameter logic [BIT_WIDTH-1:0] INIT_VAL     = '0
) (
    input logic               clk_i,
    input logic               rst_n_i,
    tech_ram_1r1w_bm_if.slave ram_io
);
    localparam int unsigned           ADDR_WIDTH = $clog2(WORD_DEPTH);
    localparam int unsigned           BM_WIDTH   = BIT_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LastAddr   = ADDR_WIDTH'(WORD_DEPTH - 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("tech_ram_1r1w_bm: READ_LATENCY must be 1 or 2");
    end
    if (BIT_WIDTH % 8 != 0) begin : g_bad_width
        $error("tech_ram_1r1w_bm: BIT_WIDTH must be a multiple of 8");
    end
    if (WORD_DEPTH < 2) begin : g_bad_depth
        $error("tech_ram_1r1w_bm: WORD_DEPTH must be at least 2");
    end

    typedef enum logic {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Addresses past the last word only exist when the depth is not a power of two.
    logic wr_in_range;
    logic rd_in_range;
    if ((1 << ADDR_WIDTH) == WORD_DEPTH) begin : g_pow2
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_npow2
        localparam logic [ADDR_WIDTH:0] Depth = (ADDR_WIDTH + 1)'(WORD_DEPTH);
        assign wr_in_range = ({1'b0, ram_io.wr_addr_i} < Depth);
        assign rd_in_range = ({1'b0, ram_io.rd_addr_i} < Depth);
    end

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [BM_WIDTH-1:0]   mem_wbe;
    logic [BIT_WIDTH-1:0]  mem_wdat;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ram_io.wr_addr_i;
        mem_wbe   = ram_io.wr_bm_i;
        mem_wdat  = ram_io.wr_dat_i;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wbe   = '1;
            mem_wdat  = INIT_VAL;
        end else if (ram_io.wr_en_i && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; the backend replaces this block with a macro.
    logic [BIT_WIDTH-1:0] mem_q [WORD_DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) begin
            for (int unsigned i = 0; i < BM_WIDTH; i++) begin
                if (mem_wbe[i]) begin
                    mem_q[mem_waddr][i*8 +: 8] <= mem_wdat[i*8 +: 8];
                end
            end
        end
    end

    logic                 rd_accept;
    logic [BIT_WIDTH-1:0] rd_word;

    always_comb begin
        rd_accept = (state_q == StRun) && ram_io.rd_en_i;
        rd_word   = rd_in_range ? mem_q[ram_io.rd_addr_i] : '0;
`ifdef TECH_RAM_BYPASS_EN
        if (ram_io.wr_en_i && wr_in_range && (ram_io.wr_addr_i == ram_io.rd_addr_i)) begin
            for (int unsigned i = 0; i < BM_WIDTH; i++) begin
                if (ram_io.wr_bm_i[i]) begin
                    rd_word[i*8 +: 8] = ram_io.wr_dat_i[i*8 +: 8];
                end
            end
        end
`endif
    end

    logic                 pipe_vld;
    logic [BIT_WIDTH-1:0] pipe_dat;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                 stg_vld_q, stg_vld_d;
        logic [BIT_WIDTH-1:0] stg_dat_q, stg_dat_d;

        always_comb begin
            stg_vld_d = rd_accept;
            stg_dat_d = rd_word;
        end

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                stg_vld_q <= 1'b0;
                stg_dat_q <= '0;
            end else begin
                stg_vld_q <= stg_vld_d;
                stg_dat_q <= stg_dat_d;
            end
        end

        assign pipe_vld = stg_vld_q;
        assign pipe_dat = stg_dat_q;
    end else begin : g_lat1
        assign pipe_vld = rd_accept;
        assign pipe_dat = rd_word;
    end

    logic                 rd_valid_q, rd_valid_d;
    logic [BIT_WIDTH-1:0] rd_dat_q, rd_dat_d;

    always_comb begin
        rd_valid_d = pipe_vld;
        rd_dat_d   = pipe_vld ? pipe_dat : rd_dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_valid_q <= 1'b0;
            rd_dat_q   <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    assign ram_io.init_busy_o = (state_q == StInit);
    assign ram_io.rd_valid_o  = rd_valid_q;
    assign ram_io.rd_dat_o    = rd_dat_q;
endmodule

// File: tb/tb_tech_ram_1r1w_bm.sv
// Bench for tech_ram_1r1w_bm: a 256-word latency-1 RAM and a 12-word latency-2 RAM side by side,
// checked every cycle against an array/schedule reference model plus directed vectors.
module tb_tech_ram_1r1w_bm;
    localparam int unsigned D0    = 256;
    localparam int unsigned D1    = 12;
    localparam logic [63:0] Init0 = 64'h0;
    localparam logic [63:0] Init1 = 64'h5A5A_0123_4567_89AB;
`ifdef TECH_RAM_BYPASS_EN
    localparam logic [63:0] Col0  = 64'hDEAD_BEEF_0000_1234;
    localparam logic [63:0] Col1  = 64'h11AD_BEEF_0000_1211;
`else
    localparam logic [63:0] Col0  = 64'h0;
    localparam logic [63:0] Col1  = 64'hDEAD_BEEF_0000_1234;
`endif

    logic clk = 1'b0;
    logic rst0_n;
    logic rst1_n;
    always #5 clk = ~clk;

    tech_ram_1r1w_bm_if #(.BIT_WIDTH(64), .WORD_DEPTH(D0)) if0 ();
    tech_ram_1r1w_bm_if #(.BIT_WIDTH(64), .WORD_DEPTH(D1)) if1 ();

    tech_ram_1r1w_bm #(
        .BIT_WIDTH(64), .WORD_DEPTH(D0), .READ_LATENCY(1), .INIT_VAL(Init0)
    ) u_dut0 (
        .clk_i(clk), .rst_n_i(rst0_n), .ram_io(if0)
    );

    tech_ram_1r1w_bm #(
        .BIT_WIDTH(64), .WORD_DEPTH(D1), .READ_LATENCY(2), .INIT_VAL(Init1)
    ) u_dut1 (
        .clk_i(clk), .rst_n_i(rst1_n), .ram_io(if1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, init progress, and read results scheduled by due edge.
    logic [63:0] m_mem [2][256];
    bit          m_live [2];
    bit          m_busy [2];
    int unsigned m_cnt [2];
    bit          m_pv [2][4];
    logic [63:0] m_pd [2][4];
    bit          m_vld [2];
    logic [63:0] m_dat [2];
    int unsigned cyc = 0;

    function automatic int unsigned depth_of(int k);
        return (k == 0) ? D0 : D1;
    endfunction

    function automatic logic [63:0] init_of(int k);
        return (k == 0) ? Init0 : Init1;
    endfunction

    task automatic model_edge(int k, bit rst_n, bit wen, int unsigned wa, logic [7:0] bm,
                              logic [63:0] wd, bit ren, int unsigned ra);
        logic [63:0] rd;
        int unsigned lat;
        int unsigned slot;
        lat  = (k == 0) ? 1 : 2;
        slot = cyc % 4;
        if (!rst_n) begin
            m_live[k] = 1'b1;
            m_busy[k] = 1'b1;
            m_cnt[k]  = 0;
            m_vld[k]  = 1'b0;
            m_dat[k]  = '0;
            for (int s = 0; s < 4; s++) m_pv[k][s] = 1'b0;
            return;
        end
        if (!m_live[k]) return;
        if (m_busy[k]) begin
            m_mem[k][m_cnt[k]] = init_of(k);
            m_cnt[k]++;
            if (m_cnt[k] == depth_of(k)) m_busy[k] = 1'b0;
        end else begin
            if (ren) begin
                rd = (ra < depth_of(k)) ? m_mem[k][ra] : 64'h0;
`ifdef TECH_RAM_BYPASS_EN
                if (wen && wa == ra && ra < depth_of(k)) begin
                    for (int b = 0; b < 8; b++) if (bm[b]) rd[b*8 +: 8] = wd[b*8 +: 8];
                end
`endif
                m_pv[k][(cyc + lat - 1) % 4] = 1'b1;
                m_pd[k][(cyc + lat - 1) % 4] = rd;
            end
            if (wen && wa < depth_of(k)) begin
                for (int b = 0; b < 8; b++) if (bm[b]) m_mem[k][wa][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        m_vld[k] = m_pv[k][slot];
        if (m_pv[k][slot]) m_dat[k] = m_pd[k][slot];
        m_pv[k][slot] = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_edge(0, rst0_n, if0.wr_en_i, 32'(if0.wr_addr_i), if0.wr_bm_i, if0.wr_dat_i,
                   if0.rd_en_i, 32'(if0.rd_addr_i));
        model_edge(1, rst1_n, if1.wr_en_i, 32'(if1.wr_addr_i), if1.wr_bm_i, if1.wr_dat_i,
                   if1.rd_en_i, 32'(if1.rd_addr_i));
    end

    always @(negedge clk) begin
        if (m_live[0]) begin
            chk("busy0", 64'(if0.init_busy_o), 64'(m_busy[0]));
            chk("valid0", 64'(if0.rd_valid_o), 64'(m_vld[0]));
            chk("rdat0", if0.rd_dat_o, m_dat[0]);
        end
        if (m_live[1]) begin
            chk("busy1", 64'(if1.init_busy_o), 64'(m_busy[1]));
            chk("valid1", 64'(if1.rd_valid_o), 64'(m_vld[1]));
            chk("rdat1", if1.rd_dat_o, m_dat[1]);
        end
    end

    task automatic drive(int k, bit wen, int unsigned wa, logic [7:0] bm, logic [63:0] wd,
                         bit ren, int unsigned ra);
        if (k == 0) begin
            if0.wr_en_i   = wen;
            if0.wr_addr_i = 8'(wa);
            if0.wr_bm_i   = bm;
            if0.wr_dat_i  = wd;
            if0.rd_en_i   = ren;
            if0.rd_addr_i = 8'(ra);
        end else begin
            if1.wr_en_i   = wen;
            if1.wr_addr_i = 4'(wa);
            if1.wr_bm_i   = bm;
            if1.wr_dat_i  = wd;
            if1.rd_en_i   = ren;
            if1.rd_addr_i = 4'(ra);
        end
    endtask

    typedef struct {
        bit          wen;
        int unsigned wa;
        logic [7:0]  bm;
        logic [63:0] wd;
        bit          ren;
        int unsigned ra;
        bit          ev;
        logic [63:0] ed;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    initial begin
        int n0;
        int n1;
        bit saw_vld0;
        bit v0 [8];
        bit v1 [8];

        vec[0]  = '{1'b1, 3,   8'hFF, 64'h1111_2222_3333_4444, 1'b0, 0,   1'b0, 64'h0};
        vec[1]  = '{1'b1, 3,   8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0,   1'b0, 64'h0};
        vec[2]  = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 3,   1'b1, 64'h1111_2222_FFFF_FFFF};
        vec[3]  = '{1'b1, 7,   8'hFF, 64'hDEAD_BEEF_0000_1234, 1'b1, 7, 1'b1, Col0};
        vec[4]  = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 7,   1'b1, 64'hDEAD_BEEF_0000_1234};
        vec[5]  = '{1'b1, 0,   8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0, 64'h0};
        vec[6]  = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 0,   1'b1, Init0};
        vec[7]  = '{1'b1, 7,   8'h81, 64'h1111_1111_1111_1111, 1'b1, 7, 1'b1, Col1};
        vec[8]  = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 7,   1'b1, 64'h11AD_BEEF_0000_1211};
        vec[9]  = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 5,   1'b1, Init0};
        vec[10] = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 128, 1'b1, Init0};
        vec[11] = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 255, 1'b1, Init0};
        vec[12] = '{1'b1, 3,   8'h30, 64'h0000_ABCD_0000_0000, 1'b0, 0, 1'b0, 64'h0};
        vec[13] = '{1'b0, 0,   8'h00, 64'h0, 1'b1, 3,   1'b1, 64'h1111_ABCD_FFFF_FFFF};

        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(negedge clk);

        // Release reset with requests held active; they must be ignored while initialising.
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        drive(0, 1, 5, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1, 5);
        drive(1, 1, 5, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1, 5);
        n0 = 0;
        n1 = 0;
        saw_vld0 = 1'b0;
        while (if0.init_busy_o && n0 < 1000) begin
            n0++;
            if (if1.init_busy_o) n1++;
            else drive(1, 0, 0, 0, 0, 0, 0);
            saw_vld0 |= if0.rd_valid_o;
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("init_len0", 64'(n0), 64'd256);
        chk("init_len1", 64'(n1), 64'd12);
        chk("no_valid_in_init", 64'(saw_vld0), 64'd0);

        for (int i = 0; i < NV; i++) begin
            drive(0, vec[i].wen, vec[i].wa, vec[i].bm, vec[i].wd, vec[i].ren, vec[i].ra);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(if0.rd_valid_o), 64'(vec[i].ev));
            if (vec[i].ev) chk($sformatf("vec%0d_data", i), if0.rd_dat_o, vec[i].ed);
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // Back-to-back reads of words 0,1,2 on both latencies.
        for (int t = 0; t < 8; t++) begin
            drive(0, 0, 0, 0, 0, t < 3, 32'(t));
            drive(1, 0, 0, 0, 0, t < 3, 32'(t));
            @(negedge clk);
            v0[t] = if0.rd_valid_o;
            v1[t] = if1.rd_valid_o;
            if (t >= 1 && t <= 3) chk("lat2_data", if1.rd_dat_o, Init1);
        end
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("lat1_valid%0d", t), 64'(v0[t]), 64'(t < 3));
            chk($sformatf("lat2_valid%0d", t), 64'(v1[t]), 64'(t >= 1 && t <= 3));
        end

        // Write landing between the two read edges is not seen by the read.
        drive(1, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        drive(1, 1, 4, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("late_wr_valid", 64'(if1.rd_valid_o), 64'd1);
        chk("late_wr_data", if1.rd_dat_o, Init1);
        drive(1, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("late_wr_readback", if1.rd_dat_o, 64'h0123_4567_89AB_CDEF);

        // Out-of-range address on the 12-word RAM.
        drive(1, 1, 13, 8'hFF, 64'hFFFF_0000_FFFF_0000, 1, 13);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("oor_valid", 64'(if1.rd_valid_o), 64'd1);
        chk("oor_data", if1.rd_dat_o, 64'h0);

        // Reset one cycle after a latency-2 read request.
        drive(1, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        rst1_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 64'(if1.rd_valid_o), 64'd0);
        chk("rst_mid_data", if1.rd_dat_o, 64'h0);
        chk("rst_mid_busy", 64'(if1.init_busy_o), 64'd1);
        @(negedge clk);
        chk("rst_mid_valid2", 64'(if1.rd_valid_o), 64'd0);
        rst1_n = 1'b1;
        n1 = 0;
        while (if1.init_busy_o && n1 < 100) begin
            n1++;
            @(negedge clk);
        end
        chk("reinit_len1", 64'(n1), 64'd12);

        // Random traffic on both RAMs, occasionally resetting the small one.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                int unsigned ra;
                int unsigned wa;
                ra = (k == 0) ? $urandom_range(0, 15) : $urandom_range(0, 15);
                if (k == 0 && $urandom_range(0, 3) == 0) ra = $urandom_range(0, 255);
                wa = ($urandom_range(0, 2) == 0) ? ra : $urandom_range(0, 15);
                drive(k, 1'($urandom_range(0, 1)), wa, 8'($urandom), {$urandom, $urandom},
                      1'($urandom_range(0, 1)), ra);
            end
            rst1_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        rst1_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
